melody_sequencer: RTL
=====================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6: note table address width (2^ADDR_W entries).
REQ-002 Parameter TICK_DIV, default 50000: clk cycles per duration tick (1 ms at 50 MHz); legal range >= 2.
REQ-003 Parameter GAP_TICKS, default 10: silent ticks between notes (used only with MELODY_SEQ_GAP_EN).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  begin playback from entry 0.
REQ-007 abort  input  1  terminate playback immediately.
REQ-008 loop  input  1  repeat melody; sampled only with an accepted start.
REQ-009 tbl_we / tbl_addr / tbl_freq / tbl_dur  input  1 / ADDR_W / 32 / 16  table write port: write enable, entry index, tone divider, duration in ticks.
REQ-010 freq  output  32  divider for the tone generator.
REQ-011 stop  output  1  tone generator silence request (1 = silent).
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on natural melody end.
REQ-014 note_idx  output  ADDR_W  index of entry being fetched or played.

Function
REQ-015 Table SHALL be synchronous-read RAM, written on any cycle with tbl_we=1; writes never disturb the note already latched in freq/duration counter.
REQ-016 States SHALL be IDLE, FETCH, CHECK, PLAY, GAP (macro only), FINISH.
REQ-017 IDLE: stop=1; start=1 and abort=0 -> FETCH, note_idx=0, loop latched; start while busy SHALL be ignored.
REQ-018 FETCH (1 cycle): read address = note_idx; -> CHECK.
REQ-019 CHECK: tbl_dur=0 is terminator; terminator with latched loop=1 and note_idx!=0 -> FETCH with note_idx=0; terminator otherwise -> FINISH; else freq<=tbl_freq, duration counter<=tbl_dur, prescaler cleared, -> PLAY.
REQ-020 Latency: start sampled at edge k -> stop=0 and new freq visible after edge k+2.
REQ-021 PLAY: stop=0 for exactly tbl_dur*TICK_DIV cycles; prescaler wraps at TICK_DIV-1, each wrap decrements duration; final tick -> next-note step.
REQ-022 Next-note step: note_idx=2^ADDR_W-1 SHALL behave as terminator (wrap-around -> loop to 0 or FINISH); otherwise note_idx+1 -> FETCH.
REQ-023 stop=1 in FETCH/CHECK, giving a 2-cycle inter-note silence without the macro.
REQ-024 FINISH (1 cycle): done=1, stop=1, -> IDLE.
REQ-025 abort=1 in any non-IDLE state -> IDLE at next edge, stop=1, done=0; abort has priority over start and over every transition.
REQ-026 freq SHALL hold its last value while stop=1.
REQ-027 Empty table (entry 0 terminator) with loop=1 SHALL go to FINISH, never livelock.

Reset
REQ-028 reset=1 SHALL force IDLE, freq=0, stop=1, busy=0, done=0, note_idx=0, counters 0, latched loop=0; table contents SHALL NOT be cleared.
REQ-029 reset has priority over abort, start and table writes; reset mid-note silences at next edge.

Configuration
REQ-030 Macro MELODY_SEQ_GAP_EN defined: after each PLAY the block SHALL enter GAP, stop=1 for GAP_TICKS*TICK_DIV cycles, then do next-note step; abort applies in GAP.
REQ-031 Macro undefined: no GAP state or gap counter; PLAY goes directly to next-note step.

Verification (TICK_DIV=4, ADDR_W=3, GAP_TICKS=2)
REQ-032 Entries {100,2},{200,1},{x,0}; start, loop=0 -> stop=0 freq=100 for 8 cycles, 2 silent, freq=200 for 4 cycles, done pulse, busy=0.
REQ-033 Same table, loop=1 -> melody repeats 100/200 indefinitely, done never pulses; abort mid-note -> stop=1 next edge, busy=0, no done.
REQ-034 Entry 0 dur=0, loop=1, start -> done pulse 3 cycles after start, no PLAY cycle.
REQ-035 All 8 entries dur=1, loop=0 -> 8 notes, note_idx 0..7, then done (wrap terminator); start held during playback -> ignored.
REQ-036 Macro defined, REQ-032 table -> silent gap of 8 cycles plus 2 fetch cycles between notes; reset asserted in GAP -> all outputs at reset values next edge.

Source files
------------

// File: rtl/melody_sequencer.sv
// Table-driven melody sequencer: plays (freq, duration) entries until a terminator.
// Define MELODY_SEQ_GAP_EN to insert a timed silent gap after every note.
module melody_sequencer #(
   parameter int ADDR_W    = 6,
   parameter int TICK_DIV  = 50000,
   parameter int GAP_TICKS = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic              loop,
   input  logic              tbl_we,
   input  logic [ADDR_W-1:0] tbl_addr,
   input  logic [31:0]       tbl_freq,
   input  logic [15:0]       tbl_dur,
   output logic [31:0]       freq,
   output logic              stop,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] note_idx
);

   localparam int PW = $clog2(TICK_DIV);

   if (TICK_DIV < 2 || GAP_TICKS < 1) begin : g_param_chk
      $error("melody_sequencer: need TICK_DIV >= 2 and GAP_TICKS >= 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CHECK,
      S_PLAY,
`ifdef MELODY_SEQ_GAP_EN
      S_GAP,
`endif
      S_FINISH
   } state_t;

   state_t            state_q;
   logic [47:0]       mem_q [2**ADDR_W];
   logic [47:0]       rd_q;
   logic [31:0]       freq_q;
   logic              stop_q;
   logic              done_q;
   logic              loop_q;
   logic [ADDR_W-1:0] idx_q;
   logic [ADDR_W-1:0] idx_d;
   logic [15:0]       dur_q;
   logic [PW-1:0]     presc_q;
   logic              tick;
   logic              last_idx;
`ifdef MELODY_SEQ_GAP_EN
   logic [15:0]       gap_q;
`endif

   assign idx_d    = idx_q + 1'b1;
   assign tick     = (presc_q == PW'(TICK_DIV - 1));
   assign last_idx = &idx_q;

   // Table contents survive reset; only the write is blocked while it is held.
   always_ff @(posedge clk) begin
      if (tbl_we && !reset) begin
         mem_q[tbl_addr] <= {tbl_freq, tbl_dur};
      end
      rd_q <= mem_q[idx_q];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         freq_q  <= '0;
         stop_q  <= 1'b1;
         done_q  <= 1'b0;
         loop_q  <= 1'b0;
         idx_q   <= '0;
         dur_q   <= '0;
         presc_q <= '0;
`ifdef MELODY_SEQ_GAP_EN
         gap_q   <= '0;
`endif
      end else if (abort && state_q != S_IDLE) begin
         state_q <= S_IDLE;
         stop_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_q <= S_FETCH;
                  idx_q   <= '0;
                  loop_q  <= loop;
               end
            end
            S_FETCH: state_q <= S_CHECK;
            S_CHECK: begin
               if (rd_q[15:0] == '0) begin
                  if (loop_q && idx_q != '0) begin
                     idx_q   <= '0;
                     state_q <= S_FETCH;
                  end else begin
                     state_q <= S_FINISH;
                     done_q  <= 1'b1;
                  end
               end else begin
                  freq_q  <= rd_q[47:16];
                  dur_q   <= rd_q[15:0];
                  presc_q <= '0;
                  stop_q  <= 1'b0;
                  state_q <= S_PLAY;
               end
            end
            S_PLAY: begin
               presc_q <= tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  dur_q <= dur_q - 1'b1;
                  if (dur_q == 16'd1) begin
                     stop_q <= 1'b1;
`ifdef MELODY_SEQ_GAP_EN
                     gap_q   <= 16'(GAP_TICKS);
                     state_q <= S_GAP;
`else
                     // The last entry index doubles as a terminator.
                     if (last_idx && !loop_q) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                     end else begin
                        idx_q   <= idx_d;
                        state_q <= S_FETCH;
                     end
`endif
                  end
               end
            end
`ifdef MELODY_SEQ_GAP_EN
            S_GAP: begin
               presc_q <= tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  gap_q <= gap_q - 1'b1;
                  if (gap_q == 16'd1) begin
                     if (last_idx && !loop_q) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                     end else begin
                        idx_q   <= idx_d;
                        state_q <= S_FETCH;
                     end
                  end
               end
            end
`endif
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   assign freq     = freq_q;
   assign stop     = stop_q;
   assign done     = done_q;
   assign busy     = (state_q != S_IDLE);
   assign note_idx = idx_q;

endmodule
